// File: rtl/cfg_types_pkg.sv
// -----------------------------------------------------------------------------
// cfg_types_pkg
// Shared type definitions for the accelerator configuration/control blocks.
//   arb_state_t : accel_mem_arbiter FSM states (round-robin / accel-locked)
//   arb_owner_t : identifies which requester owns a RAM access
// -----------------------------------------------------------------------------
package cfg_types_pkg;

   typedef enum logic {
      ST_ARB  = 1'b0,
      ST_LOCK = 1'b1
   } arb_state_t;

   typedef enum logic {
      OWN_HOST  = 1'b0,
      OWN_ACCEL = 1'b1
   } arb_owner_t;

endpackage : cfg_types_pkg

// File: rtl/accel_mem_arbiter.sv
// -----------------------------------------------------------------------------
// accel_mem_arbiter
// Shares one port of the accelerator local RAM between the host bus slave and
// the accelerator control FSM. Round-robin arbitration; the accelerator can
// lock the port for burst transfers, while a bounded lock counter hands the
// host one slot after MAX_LOCK consecutive accel grants.
//
// Ports:
//   clk, rst_n                  clock, asynchronous active-low reset
//   h_req/h_gnt, a_req/a_gnt    request / same-cycle grant per requester
//   h_addr/h_we/h_wdata/h_be    host access fields
//   a_addr/a_we/a_wdata/a_be    accel access fields
//   a_lock                      accel asks to own the port (only with a_req)
//   h_rvalid/h_rdata            host read return, one cycle after grant
//   a_rvalid/a_rdata            accel read return, one cycle after grant
//   mem_en/addr/we/wdata/be     RAM port, driven by the granted requester
//   mem_rdata                   RAM read data, one-cycle latency
//   locked                      port currently held by the accelerator
// -----------------------------------------------------------------------------
module accel_mem_arbiter
   import cfg_types_pkg::*;
#(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32,
   parameter int MAX_LOCK   = 8
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    h_req,
   output logic                    h_gnt,
   input  logic [ADDR_WIDTH-1:0]   h_addr,
   input  logic                    h_we,
   input  logic [DATA_WIDTH-1:0]   h_wdata,
   input  logic [DATA_WIDTH/8-1:0] h_be,
   output logic                    h_rvalid,
   output logic [DATA_WIDTH-1:0]   h_rdata,
   input  logic                    a_req,
   output logic                    a_gnt,
   input  logic [ADDR_WIDTH-1:0]   a_addr,
   input  logic                    a_we,
   input  logic [DATA_WIDTH-1:0]   a_wdata,
   input  logic [DATA_WIDTH/8-1:0] a_be,
   input  logic                    a_lock,
   output logic                    a_rvalid,
   output logic [DATA_WIDTH-1:0]   a_rdata,
   output logic                    mem_en,
   output logic [ADDR_WIDTH-1:0]   mem_addr,
   output logic                    mem_we,
   output logic [DATA_WIDTH-1:0]   mem_wdata,
   output logic [DATA_WIDTH/8-1:0] mem_be,
   input  logic [DATA_WIDTH-1:0]   mem_rdata,
   output logic                    locked
);

   localparam int             CW      = $clog2(MAX_LOCK + 1);
   localparam logic [CW-1:0]  CNT_MAX = CW'(MAX_LOCK);

   arb_state_t    state;
   arb_owner_t    last_owner;
   arb_owner_t    rd_owner;
   logic [CW-1:0] lock_cnt;
   logic          rd_pend;

   logic          lock_hold;
   logic          host_turn;
   arb_owner_t    eff_last;

   function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
      return (v == CNT_MAX) ? v : v + 1'b1;
   endfunction

   // Grant decision: combinational from requests and registered state
   always_comb begin
      // Lock only persists while the accel keeps both req and lock up;
      // otherwise this cycle is already treated as round-robin.
      lock_hold = (state == ST_LOCK) && a_req && a_lock;
      host_turn = lock_hold && h_req && (lock_cnt == CNT_MAX);
      // Leaving the lock, the accel counts as the last owner so a waiting
      // host wins the tie immediately.
      eff_last  = (state == ST_LOCK) ? OWN_ACCEL : last_owner;
      h_gnt     = 1'b0;
      a_gnt     = 1'b0;
      if (lock_hold) begin
         if (host_turn) h_gnt = 1'b1;
         else           a_gnt = 1'b1;
      end else if (h_req && a_req) begin
         if (eff_last == OWN_ACCEL) h_gnt = 1'b1;
         else                       a_gnt = 1'b1;
      end else begin
         h_gnt = h_req;
         a_gnt = a_req;
      end
   end

   // RAM port mux
   always_comb begin
      mem_en    = h_gnt | a_gnt;
      mem_addr  = '0;
      mem_we    = 1'b0;
      mem_wdata = '0;
      mem_be    = '0;
      if (h_gnt) begin
         mem_addr  = h_addr;
         mem_we    = h_we;
         mem_wdata = h_wdata;
         mem_be    = h_be;
      end else if (a_gnt) begin
         mem_addr  = a_addr;
         mem_we    = a_we;
         mem_wdata = a_wdata;
         mem_be    = a_be;
      end
   end

   // FSM, lock counter and read-return tag
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= ST_ARB;
         last_owner <= OWN_ACCEL;
         lock_cnt   <= '0;
         rd_pend    <= 1'b0;
         rd_owner   <= OWN_HOST;
      end else begin
         if (h_gnt)      last_owner <= OWN_HOST;
         else if (a_gnt) last_owner <= OWN_ACCEL;

         case (state)
            ST_ARB: begin
               if (a_gnt && a_lock) begin
                  state    <= ST_LOCK;
                  lock_cnt <= CW'(1);
               end
            end
            ST_LOCK: begin
               if (!lock_hold) begin
                  state    <= ST_ARB;
                  lock_cnt <= '0;
               end else if (host_turn) begin
                  lock_cnt <= '0;
               end else begin
                  lock_cnt <= sat_inc(lock_cnt);
               end
            end
            default: state <= ST_ARB;
         endcase

         rd_pend  <= (h_gnt | a_gnt) & ~mem_we;
         rd_owner <= a_gnt ? OWN_ACCEL : OWN_HOST;
      end
   end

   // Read return: one cycle after grant, routed by the registered owner tag
   assign h_rvalid = rd_pend && (rd_owner == OWN_HOST);
   assign a_rvalid = rd_pend && (rd_owner == OWN_ACCEL);
   assign h_rdata  = mem_rdata;
   assign a_rdata  = mem_rdata;
   assign locked   = lock_hold;

endmodule : accel_mem_arbiter
